// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, frame constants and baud helper for the UART transmitter
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int DATA_BITS = 8;
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: loadable down-counter producing a one-cycle bit_done tick every `cycles` clocks
module uart_baud_gen #(
    parameter int MAX_CYCLES = 868,
    localparam int CW = $clog2(MAX_CYCLES),
    localparam int LW = $clog2(MAX_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic [LW-1:0] cycles,
    output logic          bit_done
);
    logic [CW-1:0] count;
    assign bit_done = count == '0;
    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else if (clear || bit_done) count <= CW'(cycles - LW'(1));
        else count <= count - CW'(1);
    end
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8-bit LSB-first UART transmitter with registered txd/tx_ready outputs
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE),
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       transmitter_start,
    input  logic [7:0] transmitter_data,
    output logic       tx_ready,
    output logic       txd
);
    localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
    localparam int LW = $clog2(STOP_LEN + 1);
    localparam int IW = $clog2(DATA_BITS);
    state_t state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [IW-1:0] idx, idx_n;
    logic [LW-1:0] cycles;
    logic clear, bit_done, txd_n;
    // The reload length is chosen for the cell that follows the current one.
    assign cycles = (state == DATA && idx == IW'(DATA_BITS - 1)) ? LW'(STOP_LEN) : LW'(CLKS_PER_BIT);
    uart_baud_gen #(.MAX_CYCLES(STOP_LEN)) baud (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .cycles(cycles),
        .bit_done(bit_done)
    );
    always_comb begin
        state_n = state;
        shift_n = shift;
        idx_n   = idx;
        clear   = 1'b0;
        case (state)
            IDLE: if (transmitter_start) begin
                shift_n = transmitter_data;
                state_n = START;
                clear   = 1'b1;
            end
            START: if (bit_done) begin
                state_n = DATA;
                idx_n   = '0;
            end
            DATA: if (bit_done) begin
                shift_n = shift >> 1;
                idx_n   = idx + IW'(1);
                state_n = idx == IW'(DATA_BITS - 1) ? STOP : DATA;
            end
            default: if (bit_done) state_n = IDLE;
        endcase
        // Outputs are registered from the next state so txd/tx_ready change on the transition edge.
        txd_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            idx      <= '0;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            idx      <= idx_n;
            txd      <= txd_n;
            tx_ready <= state_n == IDLE;
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: randomized self-checking bench comparing txd against an ideal 8N1 frame model
module tb_uart_transmitter;
    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;
    logic clk = 1'b0, rst = 1'b1, transmitter_start = 1'b0;
    logic [7:0] transmitter_data = 8'h00;
    logic tx_ready, txd;
    int checks = 0, failures = 0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    uart_transmitter #(.CLK_FREQ(400), .BAUD_RATE(100), .STOP_BITS(1)) dut (
        .clk(clk),
        .rst(rst),
        .transmitter_start(transmitter_start),
        .transmitter_data(transmitter_data),
        .tx_ready(tx_ready),
        .txd(txd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Ideal line level k cycles after acceptance: start bit, 8 data bits LSB first, stop bit.
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        int f = k / CPB;
        return f == 0 ? 1'b0 : f <= 8 ? d[f-1] : 1'b1;
    endfunction

    task automatic check_frame(input logic [7:0] d);
        for (int k = 0; k < FRAME; k++) begin
            check("frame_txd", txd, exp_bit(d, k));
            check("frame_busy", tx_ready, 1'b0);
            @(negedge clk);
        end
        check("ready_rise", tx_ready, 1'b1);
        check("stop_txd", txd, 1'b1);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", tx_ready, 1'b1);
    endtask

    task automatic send(input logic [7:0] d);
        wait_ready();
        transmitter_start = 1'b1;
        transmitter_data = d;
        @(negedge clk);
        transmitter_start = 1'b0;
        transmitter_data = 8'($urandom);
        check_frame(d);
    endtask

    task automatic count_edges(input int cycles, output int edges);
        logic prev = txd;
        edges = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (txd !== prev) edges++;
            prev = txd;
        end
    endtask

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                repeat (CPB + CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    b[i] = txd;
                    repeat (CPB) @(negedge clk);
                end
                if (txd === 1'b1) rx_q.push_back(b);
            end
        end
    end

    initial begin
        int edges;
        logic [7:0] d;
        logic [7:0] mem[3] = '{8'h11, 8'h22, 8'h33};
        int addr, n;
        logic prev_rdy, fin;
        @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_ready", tx_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_edges(100, edges);
        check("idle_edges", edges, 0);
        check("idle_ready", tx_ready, 1'b1);

        send(8'hA5);
        repeat (6) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(8'($urandom));
        end

        wait_ready();
        transmitter_start = 1'b1;
        transmitter_data = 8'h00;
        @(negedge clk);
        transmitter_data = 8'hFF;
        check_frame(8'h00);
        @(negedge clk);
        transmitter_start = 1'b0;
        check_frame(8'hFF);

        wait_ready();
        transmitter_start = 1'b1;
        transmitter_data = 8'h81;
        @(negedge clk);
        transmitter_start = 1'b0;
        fork
            check_frame(8'h81);
            begin
                repeat (10) @(negedge clk);
                transmitter_start = 1'b1;
                transmitter_data = 8'h3C;
                repeat (3) @(negedge clk);
                transmitter_start = 1'b0;
                transmitter_data = 8'($urandom);
            end
        join
        count_edges(50, edges);
        check("busy_no_frame", edges, 0);

        d = 8'($urandom);
        wait_ready();
        transmitter_start = 1'b1;
        transmitter_data = d;
        @(negedge clk);
        transmitter_start = 1'b0;
        repeat (4 * CPB + 1) @(negedge clk);
        check("mid_bit3", txd, d[3]);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_txd", txd, 1'b1);
        check("midrst_ready", tx_ready, 1'b1);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        send(8'($urandom));

        repeat (20) @(negedge clk);
        rx_q.delete();
        wait_ready();
        addr = 0;
        n = 0;
        prev_rdy = 1'b1;
        fin = 1'b0;
        transmitter_data = mem[0];
        transmitter_start = 1'b1;
        while (!fin && n < 1000) begin
            @(negedge clk);
            n++;
            if (tx_ready && !prev_rdy) begin
                addr++;
                if (addr < 3) transmitter_data = mem[addr];
                else begin
                    transmitter_start = 1'b0;
                    fin = 1'b1;
                end
            end
            prev_rdy = tx_ready;
        end
        check("sender_finish", fin, 1'b1);
        repeat (10) @(negedge clk);
        check("rx_count", rx_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check("rx_byte", i < rx_q.size() ? rx_q[i] : 8'hxx, mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
